// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave with one-word
// rx holding register and one-entry tx buffer, all in the clk domain.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   sck, mosi, cs SPI pins from the master (asynchronous, cs active low)
//   miso          serial data to the master (0 outside a frame)
//   rx_data/rx_valid/rx_ready   received word, valid/ready handshake
//   tx_data/tx_valid/tx_ready   next word to send, one-entry buffer
//   rx_overrun    1-clk pulse: completed word dropped (holding reg full)
//   tx_underrun   1-clk pulse: word boundary reached with empty tx buffer
//   frame_active  high while a frame is in progress
module spi_slave_core #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  frame_active
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sck_sr, mosi_sr, cs_sr;
  logic                   sck_s, mosi_s, cs_s;
  logic                   sck_prev, cs_prev;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift, rx_next, done_word;
  logic                   word_done;
  logic [DATA_WIDTH-1:0]  tx_shift, tx_buf;
  logic                   tx_load, tx_reload;

  // Input synchronisers; idle levels are sck low and cs deasserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sr   <= '0;
      mosi_sr  <= '0;
      cs_sr    <= '1;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs};
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
    end
  end

  assign sck_s  = sck_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;

  assign rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign tx_load = tx_valid & tx_ready;

  // cs rising wins over a coincident sck edge, so a master that drops sck
  // and releases cs together ends the frame without consuming the buffer.
  always_comb begin
    tx_reload = 1'b0;
    if (state == IDLE)
      tx_reload = cs_fall;
    else
      tx_reload = ~cs_rise & sck_fall & (bit_cnt == '0);
  end

  assign miso = frame_active & tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      frame_active <= 1'b0;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      done_word    <= '0;
      word_done    <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      tx_shift     <= '0;
      tx_buf       <= '0;
      tx_ready     <= 1'b1;
      tx_underrun  <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      word_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state        <= ACTIVE;
            frame_active <= 1'b1;
            bit_cnt      <= '0;
            rx_shift     <= '0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt   <= '0;
              word_done <= 1'b1;
              done_word <= rx_next;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (sck_fall && bit_cnt != '0) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          state        <= IDLE;
          frame_active <= 1'b0;
        end
      endcase

      // Completed words land in the holding register one clk later; a
      // same-cycle handshake frees the slot for the new word.
      if (word_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= done_word;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // A reload takes the buffer content present before this clk; a
      // coincident load refills the buffer afterwards.
      if (tx_reload) begin
        if (!tx_ready) begin
          tx_shift <= tx_buf;
        end else begin
          tx_shift    <= '0;
          tx_underrun <= 1'b1;
        end
      end

      if (tx_load) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else if (tx_reload) begin
        tx_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a bus-master task drives mode-0 frames, a
// word-level model predicts rx words, miso words and pulse counts, and a
// per-cycle compare inside tick() checks the DUT against it.
module tb_spi_slave_core;

  logic       clk, rst, sck, mosi, cs, miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;
  logic       rx_overrun, tx_underrun, frame_active;

  spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs(cs), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun),
    .frame_active(frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  logic [7:0] exp_rx[$];
  logic [7:0] mbuf;
  bit         mbuf_full = 0;
  bit         m_rx_held = 0;
  int         exp_und = 0;
  int         exp_ovr = 0;
  logic [7:0] exp_miso[4];
  logic [7:0] got_miso[4];

  // Observed
  int         und_cnt = 0;
  int         ovr_cnt = 0;
  int         vcyc = 0;
  logic [7:0] last_rx = '0;
  bit         rst_sampled = 0;

  // Frame description
  int         f_n;
  logic [7:0] f_mosi[4];
  logic [7:0] f_fill[4];
  bit         f_fill_en[4];
  int         f_cut_bits;
  bit         f_cut_rst;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Every bench wait goes through here: compare the outputs the next
  // posedge will see (and that the last posedge produced), then advance.
  task automatic tick();
    logic [7:0] e;
    if (rst_sampled) begin
      check("reset_outputs",
            {rx_data, rx_valid, tx_ready, miso, rx_overrun, tx_underrun, frame_active},
            {8'h00, 6'b010000});
    end else begin
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) begin
          check("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_rx.pop_front();
          check("rx_data", {24'h0, rx_data}, {24'h0, e});
        end
        last_rx = rx_data;
      end
      if (!frame_active) check("miso_idle", {31'h0, miso}, 32'h0);
      if (rx_valid) vcyc++;
    end
    if (rx_overrun) ovr_cnt++;
    if (tx_underrun) und_cnt++;
    @(negedge clk);
    rst_sampled = rst;
  endtask

  task automatic half();
    repeat (8) tick();
  endtask

  task automatic model_reload(input int idx);
    if (mbuf_full) begin
      exp_miso[idx] = mbuf;
      mbuf_full = 0;
    end else begin
      exp_miso[idx] = 8'h00;
      exp_und++;
    end
  endtask

  task automatic model_word_done(input logic [7:0] v);
    if (rx_ready || !m_rx_held) begin
      exp_rx.push_back(v);
      if (!rx_ready) m_rx_held = 1;
    end else begin
      exp_ovr++;
    end
  endtask

  task automatic tx_load(input logic [7:0] v);
    int n;
    n = 0;
    while (!tx_ready && n < 100) begin
      tick();
      n++;
    end
    if (!tx_ready) check("tx_ready_timeout", 32'h0, 32'h1);
    tx_data  = v;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    mbuf      = v;
    mbuf_full = 1;
  endtask

  task automatic frame();
    int bits;
    bits = 0;
    cs = 1'b0;
    model_reload(0);
    for (int w = 0; w < f_n; w++) begin
      for (int b = 7; b >= 0; b--) begin
        mosi = f_mosi[w][b];
        half();
        got_miso[w][b] = miso;
        sck = 1'b1;
        bits++;
        if (b == 5 && f_fill_en[w]) tx_load(f_fill[w]);
        if (b == 0) model_word_done(f_mosi[w]);
        half();
        if (f_cut_bits != 0 && bits == f_cut_bits) begin
          if (f_cut_rst) begin
            rst = 1'b1;
            mbuf_full = 0;
            repeat (4) tick();
            sck = 1'b0;
            cs  = 1'b1;
            repeat (2) tick();
            rst = 1'b0;
          end else begin
            sck = 1'b0;
            cs  = 1'b1;
          end
          repeat (16) tick();
          return;
        end
        if (w == f_n - 1 && b == 0) begin
          sck = 1'b0;
          cs  = 1'b1;
        end else begin
          sck = 1'b0;
          if (b == 0) model_reload(w + 1);
        end
      end
    end
    mosi = 1'b0;
    repeat (16) tick();
  endtask

  task automatic setup(input int n);
    f_n = n;
    f_cut_bits = 0;
    f_cut_rst = 0;
    for (int i = 0; i < 4; i++) begin
      f_mosi[i] = 8'h00;
      f_fill[i] = 8'h00;
      f_fill_en[i] = 0;
    end
  endtask

  task automatic finish_test(input string name, input bit chk_miso, input int exp_vcyc, input int vcyc0);
    repeat (12) tick();
    if (chk_miso)
      for (int w = 0; w < f_n; w++)
        check({name, "_miso"}, {24'h0, got_miso[w]}, {24'h0, exp_miso[w]});
    check({name, "_underruns"}, und_cnt, exp_und);
    check({name, "_overruns"}, ovr_cnt, exp_ovr);
    check({name, "_rx_pending"}, exp_rx.size(), 0);
    if (exp_vcyc >= 0) check({name, "_valid_cycles"}, vcyc - vcyc0, exp_vcyc);
  endtask

  initial begin
    int v0;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1;
    rx_ready = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (4) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Single word: send 0x3C, return 0xA5
    tx_load(8'hA5);
    setup(1);
    f_mosi[0] = 8'h3C;
    v0 = vcyc;
    frame();
    finish_test("single", 1, 1, v0);
    check("single_miso_lit", {24'h0, got_miso[0]}, 32'hA5);
    check("single_rx_lit", {24'h0, last_rx}, 32'h3C);
    check("single_und_lit", und_cnt, 0);

    // Three back-to-back words with refill during each word
    tx_load(8'h10);
    setup(3);
    f_mosi[0] = 8'h01; f_mosi[1] = 8'h02; f_mosi[2] = 8'h03;
    f_fill[0] = 8'h20; f_fill_en[0] = 1;
    f_fill[1] = 8'h30; f_fill_en[1] = 1;
    v0 = vcyc;
    frame();
    finish_test("b2b", 1, 3, v0);
    check("b2b_miso1_lit", {24'h0, got_miso[1]}, 32'h20);
    check("b2b_rx_lit", {24'h0, last_rx}, 32'h03);

    // Consumer stalled: second word overruns; buffer empty throughout
    rx_ready = 1'b0;
    setup(2);
    f_mosi[0] = 8'h11; f_mosi[1] = 8'h22;
    frame();
    repeat (4) tick();
    check("ovr_held_lit", {23'h0, rx_valid, rx_data}, {23'h0, 1'b1, 8'h11});
    check("ovr_pulse_lit", ovr_cnt, 1);
    rx_ready = 1'b1;
    tick();
    m_rx_held = 0;
    finish_test("overrun", 1, -1, 0);
    check("ovr_miso_lit", {24'h0, got_miso[1]}, 32'h00);

    // Empty tx buffer: zeros on miso, one underrun
    setup(1);
    f_mosi[0] = 8'h55;
    v0 = vcyc;
    frame();
    finish_test("underrun", 1, 1, v0);
    check("underrun_rx_lit", {24'h0, last_rx}, 32'h55);

    // Aborted partial frame, then a full one
    setup(1);
    f_mosi[0] = 8'hA7;
    f_cut_bits = 5;
    v0 = vcyc;
    frame();
    setup(1);
    f_mosi[0] = 8'hF0;
    frame();
    finish_test("abort", 1, 1, v0);
    check("abort_rx_lit", {24'h0, last_rx}, 32'hF0);

    // Reset mid-frame with a loaded buffer, then a fresh frame
    setup(1);
    f_mosi[0] = 8'h6B;
    f_fill[0] = 8'h77; f_fill_en[0] = 1;
    f_cut_bits = 3;
    f_cut_rst = 1;
    frame();
    check("rst_tx_ready_lit", {31'h0, tx_ready}, 32'h1);
    setup(1);
    f_mosi[0] = 8'h9E;
    v0 = vcyc;
    frame();
    finish_test("reset", 1, 1, v0);
    check("reset_rx_lit", {24'h0, last_rx}, 32'h9E);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
